pin_entry: RTL and testbench

- Keypad-side front end of the door-lock datapath.
- Takes one-cycle key events from the keypad scanner/debouncer and assembles up to DIGITS BCD digits into a PIN word.
- Supports backspace, clear, enter and an inactivity timeout.
- On a valid enter, issues a single-cycle compare strobe to the password checker and holds the word stable until the checker acknowledges.

---
 rtl/lock_pkg.sv | 23 ++
 rtl/pin_entry_idle_timer.sv | 35 +++
 rtl/pin_entry.sv | 159 +++++++++++++++
 tb/tb_pin_entry.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
// Shared definitions for the door-lock datapath: key codes, PIN size and
// the keypad entry state type.
package lock_pkg;

   localparam int unsigned PIN_DIGITS = 4;

   localparam logic [3:0] KEY_BKSP  = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;
   localparam logic [3:0] KEY_CLEAR = 4'hC;

   typedef enum logic [2:0] {
      IDLE,
      ENTRY,
      FULL,
      SUBMIT,
      HOLD
   } entry_state_t;

   function automatic logic is_digit(input logic [3:0] code);
      return code <= 4'd9;
   endfunction

endpackage

// File: rtl/pin_entry_idle_timer.sv
// Loadable up-counter with synchronous clear and a terminal-count flag.
// The counter saturates at LIMIT; terminal is high while enabled at LIMIT.
module idle_timer #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned LIMIT = 255
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             enable,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic             terminal
);

   logic [WIDTH-1:0] count;
   logic             at_limit;

   assign at_limit = (count == WIDTH'(LIMIT));
   assign terminal = enable && at_limit;

   // Counter register: clear has priority over load, load over counting.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (enable && !at_limit) begin
         count <= count + 1'b1;
      end
   end

endmodule

// File: rtl/pin_entry.sv
// Keypad front end: assembles BCD digits into a PIN word, handles
// backspace/clear/enter and inactivity timeout, and hands a stable word
// to the password checker with a one-cycle compare strobe.
module pin_entry
   import lock_pkg::*;
#(
   parameter int unsigned DIGITS         = PIN_DIGITS,
   parameter int unsigned TIMEOUT_CYCLES = 500_000_000
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                key_valid,
   input  logic [3:0]          key_code,
   input  logic                cmp_ack,
   output logic [4*DIGITS-1:0] pin_word,
   output logic [2:0]          digit_count,
   output logic                enb_cmp,
   output logic                entry_err,
   output logic                key_drop,
   output logic                timeout,
   output logic                busy
);

   localparam int unsigned CNT_W      = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned PIN_W      = 4 * DIGITS;
   localparam logic [2:0]  FULL_COUNT = 3'(DIGITS);

   entry_state_t     state, state_n;
   logic [PIN_W-1:0] pin_n;
   logic [2:0]       count_n;
   logic             enb_n, err_n, drop_n, timeout_n, busy_n;
   logic             tmr_clear, tmr_enable, tmr_terminal;

   // Inactivity timer runs only while a partial entry or a submit is pending.
   assign tmr_enable = (state == ENTRY) || (state == FULL) || (state == HOLD);

   idle_timer #(
      .WIDTH(CNT_W),
      .LIMIT(TIMEOUT_CYCLES - 1)
   ) u_idle_timer (
      .clk       (clk),
      .reset     (reset),
      .clear     (tmr_clear),
      .enable    (tmr_enable),
      .load      (1'b0),
      .load_value('0),
      .terminal  (tmr_terminal)
   );

   // State and all outputs are registered; everything resets to zero/IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= IDLE;
         pin_word    <= '0;
         digit_count <= '0;
         enb_cmp     <= 1'b0;
         entry_err   <= 1'b0;
         key_drop    <= 1'b0;
         timeout     <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_n;
         pin_word    <= pin_n;
         digit_count <= count_n;
         enb_cmp     <= enb_n;
         entry_err   <= err_n;
         key_drop    <= drop_n;
         timeout     <= timeout_n;
         busy        <= busy_n;
      end
   end

   // Next-state, next-word and pulse decode; a key event beats the timer,
   // an acknowledge beats both.
   always_comb begin
      state_n   = state;
      pin_n     = pin_word;
      count_n   = digit_count;
      enb_n     = 1'b0;
      err_n     = 1'b0;
      drop_n    = 1'b0;
      timeout_n = 1'b0;
      tmr_clear = 1'b0;

      case (state)
         IDLE, ENTRY, FULL: begin
            if (key_valid) begin
               tmr_clear = 1'b1;
               if (is_digit(key_code)) begin
                  if (digit_count == FULL_COUNT) begin
                     drop_n = 1'b1;
                  end else begin
                     pin_n   = {pin_word[PIN_W-5:0], key_code};
                     count_n = digit_count + 3'd1;
                     state_n = (count_n == FULL_COUNT) ? FULL : ENTRY;
                  end
               end else if (key_code == KEY_BKSP) begin
                  if (digit_count != 3'd0) begin
                     pin_n   = pin_word >> 4;
                     count_n = digit_count - 3'd1;
                     state_n = (count_n == 3'd0) ? IDLE : ENTRY;
                  end
               end else if (key_code == KEY_ENTER) begin
                  if (digit_count == FULL_COUNT) begin
                     state_n = SUBMIT;
                     enb_n   = 1'b1;
                  end else begin
                     err_n = 1'b1;
                  end
               end else if (key_code == KEY_CLEAR) begin
                  pin_n   = '0;
                  count_n = '0;
                  state_n = IDLE;
               end
            end else if (tmr_terminal) begin
               timeout_n = 1'b1;
               pin_n     = '0;
               count_n   = '0;
               state_n   = IDLE;
            end
         end

         SUBMIT: begin
            state_n = HOLD;
            drop_n  = key_valid;
         end

         HOLD: begin
            if (cmp_ack) begin
               pin_n   = '0;
               count_n = '0;
               state_n = IDLE;
               drop_n  = key_valid;
            end else if (key_valid) begin
               drop_n    = 1'b1;
               tmr_clear = 1'b1;
            end else if (tmr_terminal) begin
               timeout_n = 1'b1;
               pin_n     = '0;
               count_n   = '0;
               state_n   = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
            pin_n   = '0;
            count_n = '0;
         end
      endcase

      if ((state_n != state) || (state == IDLE)) begin
         tmr_clear = 1'b1;
      end

      busy_n = (state_n == SUBMIT) || (state_n == HOLD);
   end

endmodule

// File: tb/tb_pin_entry.sv
// Self-checking bench for pin_entry with a queue-based reference model.
module tb_pin_entry;

   localparam int unsigned DIGITS = 4;
   localparam int unsigned TO     = 20;

   localparam int PH_OPEN   = 0;
   localparam int PH_SUBMIT = 1;
   localparam int PH_WAIT   = 2;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        key_valid = 1'b0;
   logic [3:0]  key_code = 4'h0;
   logic        cmp_ack = 1'b0;
   logic [15:0] pin_word;
   logic [2:0]  digit_count;
   logic        enb_cmp, entry_err, key_drop, timeout, busy;

   int checks = 0;
   int errors = 0;

   // reference model: digits oldest first, phase of the submit handshake,
   // quiet cycles since the last activity
   int q[$];
   int phase = PH_OPEN;
   int quiet = 0;
   bit e_enb, e_err, e_drop, e_to;

   pin_entry #(.DIGITS(DIGITS), .TIMEOUT_CYCLES(TO)) dut (
      .clk        (clk),
      .reset      (reset),
      .key_valid  (key_valid),
      .key_code   (key_code),
      .cmp_ack    (cmp_ack),
      .pin_word   (pin_word),
      .digit_count(digit_count),
      .enb_cmp    (enb_cmp),
      .entry_err  (entry_err),
      .key_drop   (key_drop),
      .timeout    (timeout),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] obs();
      return {pin_word, digit_count, enb_cmp, entry_err, key_drop, timeout, busy};
   endfunction

   function automatic logic [23:0] expv();
      logic [15:0] w = '0;
      foreach (q[i]) w = (w << 4) | 16'(q[i]);
      return {w, 3'(q.size()), e_enb, e_err, e_drop, e_to, phase != PH_OPEN};
   endfunction

   task automatic model_reset();
      q.delete();
      phase = PH_OPEN;
      quiet = 0;
      e_enb = 0; e_err = 0; e_drop = 0; e_to = 0;
   endtask

   task automatic model_step(input bit kv, input int code, input bit ack);
      e_enb = 0; e_err = 0; e_drop = 0; e_to = 0;
      if (phase == PH_SUBMIT) begin
         phase = PH_WAIT;
         quiet = 0;
         e_drop = kv;
      end else if (phase == PH_WAIT) begin
         if (ack) begin
            q.delete(); phase = PH_OPEN; quiet = 0; e_drop = kv;
         end else if (kv) begin
            e_drop = 1; quiet = 0;
         end else if (quiet == TO - 1) begin
            e_to = 1; q.delete(); phase = PH_OPEN; quiet = 0;
         end else begin
            quiet++;
         end
      end else begin
         if (kv) begin
            quiet = 0;
            if (code <= 9) begin
               if (q.size() == DIGITS) e_drop = 1;
               else q.push_back(code);
            end else if (code == 10) begin
               if (q.size() > 0) void'(q.pop_back());
            end else if (code == 11) begin
               if (q.size() == DIGITS) begin phase = PH_SUBMIT; e_enb = 1; end
               else e_err = 1;
            end else if (code == 12) begin
               q.delete();
            end
         end else if (q.size() == 0) begin
            quiet = 0;
         end else if (quiet == TO - 1) begin
            e_to = 1; q.delete(); quiet = 0;
         end else begin
            quiet++;
         end
      end
   endtask

   // one clock with the given inputs, then advance the model
   task automatic drive(input bit kv, input logic [3:0] code, input bit ack);
      key_valid = kv;
      key_code  = kv ? code : 4'($urandom_range(0, 15));
      cmp_ack   = ack;
      @(posedge clk);
      #1;
      model_step(kv, int'(code), ack);
      key_valid = 1'b0;
      cmp_ack   = 1'b0;
   endtask

   // 0..15 key code, 16 quiet cycle, 17 quiet cycle with acknowledge
   task automatic drive_ev(input int ev);
      if (ev < 16) drive(1'b1, 4'(ev), 1'b0);
      else drive(1'b0, 4'h0, ev == 17);
   endtask

   task automatic test_reset();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (obs() !== 24'h0) begin
         errors++;
         $display("FAIL reset_state: got %h expected %h", obs(), 24'h0);
      end
      reset = 1'b0;
   endtask

   task automatic test_submit();
      int seq[] = '{1, 2, 3, 4, 11};
      int enb_total = 0;
      foreach (seq[i]) begin
         drive_ev(seq[i]);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL submit step %0d: got %h expected %h", i, obs(), expv());
         end
      end
      if (enb_cmp) enb_total++;
      checks++;
      if ({enb_cmp, pin_word} !== {1'b1, 16'h1234}) begin
         errors++;
         $display("FAIL submit_word: got enb=%b pin=%h expected enb=1 pin=1234", enb_cmp, pin_word);
      end
      for (int i = 0; i < 3; i++) begin
         drive_ev(i == 2 ? 17 : 16);
         if (enb_cmp) enb_total++;
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL submit_hold %0d: got %h expected %h", i, obs(), expv());
         end
         if (i < 2) begin
            checks++;
            if ({busy, pin_word} !== {1'b1, 16'h1234}) begin
               errors++;
               $display("FAIL submit_busy %0d: got busy=%b pin=%h expected busy=1 pin=1234", i, busy, pin_word);
            end
         end
      end
      checks++;
      if ({pin_word, digit_count, busy, enb_total} !== {16'h0, 3'd0, 1'b0, 32'd1}) begin
         errors++;
         $display("FAIL submit_ack: got pin=%h cnt=%0d busy=%b strobes=%0d expected 0/0/0/1",
                  pin_word, digit_count, busy, enb_total);
      end
   endtask

   task automatic test_hold_drop();
      int seq[] = '{5, 6, 10, 7, 8, 9, 11, 16, 3, 16, 17};
      foreach (seq[i]) begin
         drive_ev(seq[i]);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL hold_drop step %0d: got %h expected %h", i, obs(), expv());
         end
         if (i == 6 || i == 8) begin
            checks++;
            if ({pin_word, (i == 6 ? enb_cmp : key_drop)} !== {16'h5789, 1'b1}) begin
               errors++;
               $display("FAIL hold_word %0d: got pin=%h flag=%b expected pin=5789 flag=1",
                        i, pin_word, (i == 6 ? enb_cmp : key_drop));
            end
         end
      end
   endtask

   task automatic test_entry_err();
      int seq[] = '{1, 2, 11, 12};
      foreach (seq[i]) begin
         drive_ev(seq[i]);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL entry_err step %0d: got %h expected %h", i, obs(), expv());
         end
         if (i == 2) begin
            checks++;
            if ({entry_err, enb_cmp, pin_word, digit_count} !== {1'b1, 1'b0, 16'h0012, 3'd2}) begin
               errors++;
               $display("FAIL entry_err_pulse: got err=%b enb=%b pin=%h cnt=%0d expected 1/0/0012/2",
                        entry_err, enb_cmp, pin_word, digit_count);
            end
         end
      end
      checks++;
      if ({pin_word, digit_count, busy} !== 20'h0) begin
         errors++;
         $display("FAIL clear: got pin=%h cnt=%0d busy=%b expected 0/0/0", pin_word, digit_count, busy);
      end
   endtask

   task automatic test_timeout();
      int tos = 0;
      drive_ev(9);
      for (int i = 1; i <= 20; i++) begin
         drive_ev(16);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL timeout idle %0d: got %h expected %h", i, obs(), expv());
         end
         if (timeout) tos++;
      end
      checks++;
      if ({timeout, tos, pin_word, digit_count} !== {1'b1, 32'd1, 16'h0, 3'd0}) begin
         errors++;
         $display("FAIL timeout_fire: got to=%b pulses=%0d pin=%h cnt=%0d expected 1/1/0/0",
                  timeout, tos, pin_word, digit_count);
      end
      tos = 0;
      drive_ev(9);
      for (int i = 1; i <= 38; i++) begin
         drive_ev(i == 19 ? 8 : 16);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL timeout_rearm %0d: got %h expected %h", i, obs(), expv());
         end
         if (timeout) tos++;
      end
      checks++;
      if ({tos, pin_word, digit_count} !== {32'd0, 16'h0098, 3'd2}) begin
         errors++;
         $display("FAIL timeout_rearm_end: got pulses=%0d pin=%h cnt=%0d expected 0/0098/2",
                  tos, pin_word, digit_count);
      end
      drive_ev(12);
   endtask

   task automatic test_ignored();
      int seq[] = '{10, 4, 14, 3, 2, 1, 7, 15, 12};
      foreach (seq[i]) begin
         drive_ev(seq[i]);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL ignored step %0d: got %h expected %h", i, obs(), expv());
         end
      end
      model_reset();
   endtask

   task automatic test_reset_mid();
      int seq1[] = '{1, 2, 3, 4, 11};
      int seq2[] = '{5, 6, 7, 8, 11, 16, 16};
      int seq3[] = '{0, 0, 0, 0, 11, 16, 17};
      for (int pass = 0; pass < 2; pass++) begin
         if (pass == 0) foreach (seq1[i]) drive_ev(seq1[i]);
         else foreach (seq2[i]) drive_ev(seq2[i]);
         #1 reset = 1'b1;
         #1;
         model_reset();
         checks++;
         if (obs() !== 24'h0) begin
            errors++;
            $display("FAIL async_reset pass %0d: got %h expected %h", pass, obs(), 24'h0);
         end
         @(posedge clk);
         #1 reset = 1'b0;
         for (int i = 0; i < 4; i++) begin
            drive_ev(16);
            checks++;
            if (obs() !== expv()) begin
               errors++;
               $display("FAIL post_reset %0d/%0d: got %h expected %h", pass, i, obs(), expv());
            end
         end
      end
      foreach (seq3[i]) begin
         drive_ev(seq3[i]);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL zero_pin step %0d: got %h expected %h", i, obs(), expv());
         end
         if (i == 4) begin
            checks++;
            if ({enb_cmp, pin_word, digit_count} !== {1'b1, 16'h0000, 3'd4}) begin
               errors++;
               $display("FAIL zero_pin_submit: got enb=%b pin=%h cnt=%0d expected 1/0000/4",
                        enb_cmp, pin_word, digit_count);
            end
         end
      end
   endtask

   task automatic test_random(input int cycles, input int key_odds);
      bit         kv, ack;
      int         r;
      logic [3:0] code;
      for (int n = 0; n < cycles; n++) begin
         kv   = ($urandom_range(0, key_odds - 1) == 0);
         r    = $urandom_range(0, 19);
         code = (r < 12) ? 4'(r % 10) : (r < 18) ? 4'(r - 2) : 4'hB;
         ack  = ($urandom_range(0, 5) == 0);
         drive(kv, code, ack);
         checks++;
         if (obs() !== expv()) begin
            errors++;
            $display("FAIL random cycle %0d: got %h expected %h", n, obs(), expv());
         end
      end
   endtask

   initial begin
      test_reset();
      test_submit();
      test_hold_drop();
      test_entry_err();
      test_timeout();
      test_ignored();
      test_reset_mid();
      test_random(800, 3);
      test_random(800, 30);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
